// File: rtl/opcode_dispatch_pkg.sv
// Shared constants for the opcode dispatcher: cell word layout, mux selects,
// memory function codes, error codes and FSM state encoding.
package opcode_dispatch_pkg;

    localparam logic [3:0] MUX_IDLE = 4'h0;
    localparam logic [3:0] MUX_OP0  = 4'h1;
    localparam logic [3:0] MUX_CONS = 4'hD;
    localparam int unsigned MAX_OPCODE = 11;

    localparam logic [1:0] MEM_READ = 2'b00;

    // Cell word: [63:60] tag, [55:28] head, [27:0] tail
    localparam int TAG_LO       = 60;
    localparam int TAG_HEAD_PTR = TAG_LO + 1;
    localparam int TAG_TAIL_PTR = TAG_LO + 0;
    localparam int HEAD_HI      = 55;
    localparam int HEAD_LO      = 28;
    localparam int TAIL_LO      = 0;

    localparam logic [7:0] ERR_NONE      = 8'h00;
    localparam logic [7:0] ERR_ROOT_ATOM = 8'h01;
    localparam logic [7:0] ERR_BAD_OP    = 8'h02;
    localparam logic [7:0] ERR_WDOG      = 8'h03;
    localparam logic [7:0] ERR_EXEC      = 8'h04;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_ROOT, S_WT_ROOT, S_RD_FORM, S_WT_FORM,
        S_DECODE, S_EXEC, S_DONE, S_ERR
    } state_e;

endpackage

// File: rtl/dispatch_wdog.sv
// EXEC watchdog: cleared on EXEC entry, counts while enabled, flags WDOG-1.
module dispatch_wdog #(
    parameter int WDOG = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(WDOG + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == CW'(WDOG - 1));

endmodule

// File: rtl/opcode_dispatch.sv
// Fetches a [subject formula] root cell and its formula cell, decodes the
// formula head into an execute-block select, and supervises that block.
module opcode_dispatch
    import opcode_dispatch_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int WDOG   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] root_addr,
    output logic              busy,
    output logic              done,
    output logic [7:0]        error,
    output logic              mem_execute,
    output logic [ADDR_W-1:0] address1,
    output logic [1:0]        mem_func,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] read_data1,
    output logic              mem_own,
    output logic [3:0]        mux_sel,
    output logic [ADDR_W-1:0] exec_addr,
    output logic [DATA_W-1:0] exec_data,
    input  logic              exec_finished,
    input  logic [7:0]        exec_error
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [3:0]          sel_q, sel_d;
    logic [7:0]          err_q, err_d;
    logic                wd_clr, wd_expired;
    logic [HEAD_HI-HEAD_LO:0] head_val;

    assign head_val = data_q[HEAD_HI:HEAD_LO];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = err_q;
        wd_clr  = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                addr_d  = root_addr;
                state_d = S_RD_ROOT;
            end
            S_RD_ROOT: state_d = S_WT_ROOT;
            S_WT_ROOT: if (mem_ready) begin
                if (!read_data1[TAG_TAIL_PTR]) begin
                    err_d   = ERR_ROOT_ATOM;
                    state_d = S_ERR;
                end else begin
                    addr_d  = read_data1[TAIL_LO +: ADDR_W];
                    state_d = S_RD_FORM;
                end
            end
            S_RD_FORM: state_d = S_WT_FORM;
            S_WT_FORM: if (mem_ready) begin
                data_d  = read_data1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (data_q[TAG_HEAD_PTR]) begin
                    sel_d   = MUX_CONS;
                    wd_clr  = 1'b1;
                    state_d = S_EXEC;
                end else if (head_val <= (HEAD_HI-HEAD_LO+1)'(MAX_OPCODE)) begin
                    sel_d   = MUX_OP0 + head_val[3:0];
                    wd_clr  = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    err_d   = ERR_BAD_OP;
                    state_d = S_ERR;
                end
            end
            // A reported error outranks a simultaneous finish.
            S_EXEC: begin
                if (exec_error != ERR_NONE) begin
                    err_d   = ERR_EXEC;
                    state_d = S_ERR;
                end else if (exec_finished) begin
                    state_d = S_DONE;
                end else if (wd_expired) begin
                    err_d   = ERR_WDOG;
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= MUX_IDLE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    dispatch_wdog #(.WDOG(WDOG)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (state_q == S_EXEC),
        .expired_o (wd_expired)
    );

    // Outputs decode straight from state so reset clears them asynchronously.
    assign busy        = state_q inside {S_RD_ROOT, S_WT_ROOT, S_RD_FORM, S_WT_FORM, S_DECODE, S_EXEC};
    assign done        = (state_q == S_DONE);
    assign error       = err_q;
    assign mem_execute = state_q inside {S_RD_ROOT, S_RD_FORM};
    assign mem_own     = state_q inside {S_RD_ROOT, S_WT_ROOT, S_RD_FORM, S_WT_FORM};
    assign mem_func    = MEM_READ;
    assign address1    = addr_q;
    assign mux_sel     = (state_q == S_EXEC) ? sel_q : MUX_IDLE;
    assign exec_addr   = addr_q;
    assign exec_data   = data_q;

endmodule

// File: tb/tb_opcode_dispatch.sv
// Randomized self-checking bench for opcode_dispatch with memory and
// execute-block responders and a cell-level reference model.
module tb_opcode_dispatch;
    import opcode_dispatch_pkg::*;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] root_addr = '0;
    logic          busy, done, mem_execute, mem_own;
    logic [7:0]    error;
    logic [AW-1:0] address1, exec_addr;
    logic [1:0]    mem_func;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] read_data1 = '0;
    logic [3:0]    mux_sel;
    logic [DW-1:0] exec_data;
    logic          exec_finished = 1'b0;
    logic [7:0]    exec_error = '0;

    opcode_dispatch #(.ADDR_W(AW), .DATA_W(DW), .WDOG(WD)) dut (
        .clk(clk), .rst(rst), .start(start), .root_addr(root_addr),
        .busy(busy), .done(done), .error(error),
        .mem_execute(mem_execute), .address1(address1), .mem_func(mem_func),
        .mem_ready(mem_ready), .read_data1(read_data1), .mem_own(mem_own),
        .mux_sel(mux_sel), .exec_addr(exec_addr), .exec_data(exec_data),
        .exec_finished(exec_finished), .exec_error(exec_error)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            tests = 0;
    int            fails = 0;

    // responder configuration and observations
    int            rd_delay = 0;
    int            ex_delay = 0;
    bit            ex_never = 1'b0;
    logic [7:0]    ex_err = '0;
    logic [AW-1:0] rd_addrs[$];
    int            n_done, n_exec, n_unstable, ex_cycles;
    logic [3:0]    sel_seen;
    logic [AW-1:0] ea_seen;
    logic [DW-1:0] ed_seen;

    int            rd_cnt = -1;
    int            ex_cnt = -1;
    logic [AW-1:0] rd_a;

    initial forever begin
        @(negedge clk);
        mem_ready = 1'b0;
        exec_finished = 1'b0;
        exec_error = '0;
        if (!rst) rd_cnt = -1;
        else if (rd_cnt == 0) begin
            mem_ready = 1'b1;
            read_data1 = mem[rd_a];
            rd_cnt = -1;
        end else if (rd_cnt > 0) rd_cnt--;
        if (rst && mem_execute) begin
            rd_addrs.push_back(address1);
            rd_a = address1;
            rd_cnt = rd_delay;
        end
        if (done) n_done++;
        if (mux_sel != MUX_IDLE) begin
            if (ex_cnt < 0) begin
                ex_cnt = 0;
                sel_seen = mux_sel;
                ea_seen = exec_addr;
                ed_seen = exec_data;
                n_exec++;
            end else if (mux_sel !== sel_seen || exec_addr !== ea_seen || exec_data !== ed_seen)
                n_unstable++;
            if (mem_own) n_unstable++;
            if (!ex_never && ex_cnt >= ex_delay) begin
                exec_finished = 1'b1;
                exec_error = ex_err;
            end
            ex_cnt++;
            ex_cycles = ex_cnt;
        end else ex_cnt = -1;
    end

    function automatic logic [DW-1:0] mk(input logic [1:0] tag, input logic [27:0] head,
                                         input logic [27:0] tail);
        logic [DW-1:0] w;
        w = '0;
        w[61:60] = tag;
        w[55:28] = head;
        w[27:0]  = tail;
        return w;
    endfunction

    // Expected outcome computed directly from the cell contents.
    function automatic void ref_model(input logic [AW-1:0] ra, input bit xerr,
                                      output logic [7:0] e, output logic [3:0] sel,
                                      output int nrd, output logic [AW-1:0] fa, output bit fin);
        logic [DW-1:0] r, f;
        r = mem[ra];
        sel = 4'h0; fa = '0; fin = 1'b0; e = 8'h00; nrd = 1;
        if (r[60] == 1'b0) begin e = 8'h01; return; end
        fa = r[AW-1:0];
        f = mem[fa];
        nrd = 2;
        if (f[61]) sel = 4'hD;
        else if (f[55:28] < 28'd12) sel = 4'(f[55:28] + 28'd1);
        else begin e = 8'h02; return; end
        if (xerr) e = 8'h04;
        else fin = 1'b1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_op(input logic [AW-1:0] ra, input bit poke, input logic [AW-1:0] pa,
                          output bit timeout);
        rd_addrs.delete();
        n_done = 0; n_exec = 0; n_unstable = 0; ex_cycles = 0;
        @(posedge clk);
        #1 root_addr = ra; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; root_addr = AW'($urandom);
        if (poke) begin
            @(posedge clk);
            #1 root_addr = pa; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        timeout = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done || error != 8'h00) begin timeout = 1'b0; break; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({busy, done, error, mem_execute, address1, mem_func, mem_own, mux_sel, exec_addr, exec_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%h mex=%b a1=%h mf=%h own=%b sel=%h ea=%h ed=%h, all required 0",
                     busy, done, error, mem_execute, address1, mem_func, mem_own, mux_sel, exec_addr, exec_data);
        end
    endtask

    // Sets up a root/formula pair, runs it and checks everything against the model.
    task automatic scenario(input string nm, input logic [AW-1:0] ra, input logic [DW-1:0] rw,
                            input logic [AW-1:0] fa, input logic [DW-1:0] fw,
                            input bit poke, input logic [AW-1:0] pa);
        bit to, fin;
        logic [7:0] e;
        logic [3:0] sel;
        int nrd;
        logic [AW-1:0] efa;
        do_reset();
        mem[ra] = rw;
        mem[fa] = fw;
        ref_model(ra, ex_err != 8'h00, e, sel, nrd, efa, fin);
        run_op(ra, poke, pa, to);
        tests++;
        if (to) begin fails++; $display("FAIL %s_timeout: no done/error within 200 cycles", nm); end
        tests++;
        if (error !== e) begin fails++; $display("FAIL %s_error: got %h want %h", nm, error, e); end
        tests++;
        if (n_exec !== ((sel != 4'h0) ? 1 : 0)) begin
            fails++; $display("FAIL %s_exec_entries: got %0d want %0d", nm, n_exec, (sel != 4'h0) ? 1 : 0);
        end
        if (sel != 4'h0) begin
            tests++;
            if (sel_seen !== sel || ea_seen !== efa || ed_seen !== mem[efa]) begin
                fails++;
                $display("FAIL %s_exec_handoff: sel=%h addr=%h data=%h want sel=%h addr=%h data=%h",
                         nm, sel_seen, ea_seen, ed_seen, sel, efa, mem[efa]);
            end
        end
        tests++;
        if (rd_addrs.size() != nrd || rd_addrs[0] !== ra || (nrd == 2 && rd_addrs[1] !== efa)) begin
            fails++; $display("FAIL %s_reads: got %0d reads first=%h want %0d reads at %h/%h",
                              nm, rd_addrs.size(), rd_addrs[0], nrd, ra, efa);
        end
        tests++;
        if (n_done !== int'(fin) || n_unstable != 0 || busy !== 1'b0) begin
            fails++; $display("FAIL %s_done: done_pulses=%0d unstable=%0d busy=%b want %0d/0/0",
                              nm, n_done, n_unstable, busy, fin);
        end
    endtask

    task automatic test_basic();
        rd_delay = 2; ex_delay = 3; ex_never = 0; ex_err = 8'h00;
        scenario("basic_op3", 10'd5, mk(2'b01, 28'd9, 28'd100), 10'd100, mk(2'b00, 28'd3, 28'd0), 0, '0);
    endtask

    task automatic test_cons();
        rd_delay = 0; ex_delay = 0;
        scenario("cons", 10'd7, mk(2'b11, 28'd1, 28'd200), 10'd200, mk(2'b10, 28'd300, 28'd4), 0, '0);
    endtask

    task automatic test_root_atom();
        rd_delay = 1;
        scenario("root_atom", 10'd9, mk(2'b10, 28'd1, 28'd40), 10'd40, mk(2'b00, 28'd2, 28'd0), 0, '0);
    endtask

    task automatic test_bad_opcode();
        rd_delay = 0;
        scenario("opcode12", 10'd11, mk(2'b01, 28'd0, 28'd50), 10'd50, mk(2'b00, 28'd12, 28'd0), 0, '0);
        scenario("opcode11", 10'd12, mk(2'b01, 28'd0, 28'd51), 10'd51, mk(2'b00, 28'd11, 28'd0), 0, '0);
    endtask

    task automatic test_watchdog();
        bit to;
        do_reset();
        rd_delay = 0; ex_never = 1;
        mem[20] = mk(2'b01, 28'd0, 28'd60);
        mem[60] = mk(2'b00, 28'd0, 28'd0);
        run_op(10'd20, 0, '0, to);
        ex_never = 0;
        tests++;
        if (error !== 8'h03) begin fails++; $display("FAIL wdog_error: got %h want 03", error); end
        tests++;
        if (ex_cycles != WD) begin fails++; $display("FAIL wdog_cycles: got %0d want %0d", ex_cycles, WD); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (error !== 8'h03 || mux_sel !== 4'h0 || busy !== 1'b0) begin
            fails++; $display("FAIL err_hold: err=%h sel=%h busy=%b want 03/0/0", error, mux_sel, busy);
        end
        ex_err = 8'h05; ex_delay = 2;
        scenario("exec_err", 10'd21, mk(2'b01, 28'd0, 28'd61), 10'd61, mk(2'b00, 28'd6, 28'd0), 0, '0);
        ex_err = 8'h00;
    endtask

    task automatic test_reset_mid_read();
        bit to;
        bit seen;
        do_reset();
        rd_delay = 8; ex_delay = 1;
        mem[30] = mk(2'b01, 28'd0, 28'd70);
        mem[70] = mk(2'b00, 28'd1, 28'd0);
        rd_addrs.delete();
        @(posedge clk);
        #1 root_addr = 10'd30; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rd_addrs.size() == 2) begin seen = 1; break; end
        end
        @(posedge clk);
        #3;
        tests++;
        if (!seen || mem_own !== 1'b1) begin
            fails++; $display("FAIL mid_wt_form: reached=%0d mem_own=%b want 1/1", seen, mem_own);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({busy, done, error, mem_execute, address1, mem_func, mem_own, mux_sel, exec_addr, exec_data} !== '0) begin
            fails++; $display("FAIL mid_reset_outputs: busy=%b own=%b sel=%h a1=%h ed=%h, all required 0",
                              busy, mem_own, mux_sel, address1, exec_data);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        rd_delay = 1;
        run_op(10'd30, 0, '0, to);
        tests++;
        if (to || error !== 8'h00 || n_done != 1 || sel_seen !== 4'h2) begin
            fails++; $display("FAIL after_reset_run: timeout=%0d err=%h done=%0d sel=%h want 0/00/1/2",
                              to, error, n_done, sel_seen);
        end
    endtask

    task automatic test_back_to_back();
        rd_delay = 1; ex_delay = 0;
        mem[45] = mk(2'b01, 28'd0, 28'd90);
        mem[90] = mk(2'b00, 28'd5, 28'd0);
        // the second start lands mid-operation and must be ignored
        scenario("start_ignored", 10'd40, mk(2'b01, 28'd0, 28'd80), 10'd80, mk(2'b00, 28'd7, 28'd0), 1, 10'd45);
        begin
            bit to;
            run_op(10'd45, 0, '0, to);
            tests++;
            if (to || error !== 8'h00 || n_done != 1 || sel_seen !== 4'h6 || rd_addrs.size() != 2) begin
                fails++; $display("FAIL back_to_back: timeout=%0d err=%h done=%0d sel=%h reads=%0d want 0/00/1/6/2",
                                  to, error, n_done, sel_seen, rd_addrs.size());
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [AW-1:0] ra, fa;
            logic [1:0] rtag, ftag;
            logic [27:0] head;
            logic [DW-1:0] rw, fw;
            ra = AW'($urandom);
            fa = AW'(ra + 1 + $urandom_range(0, 1000));
            rtag = {1'($urandom), ($urandom_range(0, 9) != 0)};
            ftag = {($urandom_range(0, 3) == 0), 1'($urandom)};
            head = ($urandom_range(0, 5) == 0) ? 28'($urandom_range(12, 5000)) : 28'($urandom_range(0, 11));
            rw = mk(rtag, 28'($urandom), {18'($urandom), fa});
            fw = mk(ftag, head, 28'($urandom));
            rw[59:56] = 4'($urandom);
            fw[63:62] = 2'($urandom);
            rd_delay = $urandom_range(0, 4);
            ex_delay = $urandom_range(0, 6);
            ex_err = ($urandom_range(0, 6) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            scenario("random", ra, rw, fa, fw, 0, '0);
        end
        ex_err = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cons();
        test_root_atom();
        test_bad_opcode();
        test_watchdog();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/opcode_dispatch.md
OPCODE_DISPATCH -- requirements
Module: opcode_dispatch

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width (at most 28).
REQ-002 SHALL have parameter DATA_W, default 64, memory word width.
REQ-003 SHALL have parameter WDOG, default 1024, maximum EXEC cycles before timeout.
REQ-004 clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request from traversal to evaluate the subject/formula cell at root_addr.
REQ-006 root_addr  in  ADDR_W  address of the [subject formula] cell.
REQ-007 busy  out  1  high from accepted start until done or error.
REQ-008 done  out  1  one-cycle pulse when the selected execute block reports finished.
REQ-009 error  out  8  sticky error code; 0 means none.
REQ-010 mem_execute  out  1  one-cycle memory request strobe.
REQ-011 address1  out  ADDR_W  read address.
REQ-012 mem_func  out  2  memory function; this block issues only READ=2'b00.
REQ-013 mem_ready  in  1  read completion; read_data1 is valid in the same cycle.
REQ-014 read_data1  in  DATA_W  read word.
REQ-015 mem_own  out  1  high while this block owns the memory port.
REQ-016 mux_sel  out  4  execute-block select.
REQ-017 exec_addr  out  ADDR_W  formula cell address handed to the execute block.
REQ-018 exec_data  out  DATA_W  formula cell word handed to the execute block.
REQ-019 exec_finished  in  1  finished level from the selected execute block.
REQ-020 exec_error  in  8  error code from the selected execute block.

Function
REQ-021 Word format: [63:60] tag; tag[1]=1 means head is a pointer; tag[0]=1 means tail is a pointer; [55:28] head; [27:0] tail; pointer = field[ADDR_W-1:0].
REQ-022 States SHALL be IDLE, RD_ROOT, WT_ROOT, RD_FORM, WT_FORM, DECODE, EXEC, DONE, ERR.
REQ-023 In IDLE, start SHALL latch root_addr, set busy, and go to RD_ROOT; start SHALL be ignored in every other state.
REQ-024 RD_ROOT/RD_FORM SHALL pulse mem_execute for exactly 1 cycle with mem_func=READ and the target address, then move to the matching WT_ state.
REQ-025 The WT_ states SHALL hold until mem_ready is high, then capture read_data1; there SHALL be no timeout on memory waits.
REQ-026 In WT_ROOT, tail tag=0 (formula is an atom) SHALL go to ERR with code 8'h01; otherwise the tail pointer SHALL become the formula address and the FSM SHALL go to RD_FORM.
REQ-027 DECODE: formula head tag=1 SHALL select MUX_CONS (4'hD, autocons).
REQ-028 DECODE: head atom value n in 0..11 SHALL select 4'h1+n.
REQ-029 DECODE: head atom value greater than 11 SHALL go to ERR with code 8'h02.
REQ-030 mux_sel SHALL be MUX_IDLE (4'h0) in every state except EXEC, so each EXEC entry is an IDLE-to-select edge that the execute blocks use as their local restart.
REQ-031 In EXEC, mux_sel, exec_addr and exec_data SHALL stay stable; mem_own SHALL be 0; mem_own SHALL be 1 in RD_/WT_ states only.
REQ-032 In EXEC, when exec_error is nonzero, the FSM SHALL go to ERR with code 8'h04; this takes priority over exec_finished in the same cycle.
REQ-033 In EXEC, exec_finished SHALL go to DONE.
REQ-034 In EXEC, the watchdog counter SHALL clear on EXEC entry and increment each cycle; reaching WDOG-1 without finish SHALL go to ERR with code 8'h03.
REQ-035 DONE SHALL pulse done, clear busy, and return to IDLE: 1 cycle.
REQ-036 ERR SHALL latch error, clear busy, drive mux_sel to IDLE, and hold until reset.
REQ-037 Minimum latency from start to done SHALL be 8 cycles plus both mem_ready waits plus the execute block time.

Reset
REQ-038 Reset SHALL force IDLE, with busy, done, error, mem_execute, address1, mem_func, mem_own, mux_sel, exec_addr, exec_data and the watchdog all at 0.
REQ-039 Reset mid-operation SHALL abandon any outstanding read and drop mux_sel to IDLE immediately.

Structure
REQ-040 MUX_* codes, MEM_READ, word field positions and error codes SHALL live in the shared package.
REQ-041 The watchdog SHALL be a sub-module, dispatch_wdog.

Verification
REQ-042 root [S F], F=[0 3] with opcode atom 3, mem_ready after 2 cycles -> mux_sel=4'h4, then exec_finished -> done pulse, error=0.
REQ-043 F head is a pointer -> mux_sel=4'hD.
REQ-044 root tail is an atom -> error=8'h01, no second read issued.
REQ-045 opcode 12 -> error=8'h02, mux_sel never leaves 0.
REQ-046 WDOG=16, exec_finished never asserted -> error=8'h03 at EXEC cycle 16; exec_error=8'h05 with exec_finished asserted together -> error=8'h04.
REQ-047 rst low during WT_FORM -> all outputs 0 next cycle; a subsequent start completes normally.
